// File: rtl/axis_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator.
package axis_pattern_pkg;

  // Generator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Data pattern selectors, as driven on the mode input.
  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  // Galois LFSR feedback mask for a 32-bit word.
  localparam logic [31:0] DEFAULT_TAP_MASK = 32'h8020_0003;

endpackage

// File: rtl/axis_pattern_data.sv
// Combinational next-word generator for the four data patterns.
// With start_i high, word_i is the seed and the output is the first word of
// a packet; otherwise word_i is the current beat and the output is the next.
module axis_pattern_data
  import axis_pattern_pkg::*;
#(
  parameter int                    AXIS_WIDTH = 32,
  parameter logic [AXIS_WIDTH-1:0] TAP_MASK   = AXIS_WIDTH'(DEFAULT_TAP_MASK)
) (
  input  logic [AXIS_WIDTH-1:0] word_i,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  output logic [AXIS_WIDTH-1:0] next_o
);

  localparam logic [AXIS_WIDTH-1:0] ONE  = AXIS_WIDTH'(1);
  localparam logic [AXIS_WIDTH-1:0] ZERO = '0;

  // Start-word substitution or per-pattern next-word rule.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a path that leaves next_o unassigned would infer a latch.
    next_o = word_i;
    if (start_i) begin
      // An all-zero LFSR state locks up and an all-zero walking word has no
      // bit to walk, so both start from 1 instead.
      if ((mode_i == MODE_LFSR || mode_i == MODE_WALK) && word_i == ZERO) begin
        next_o = ONE;
      end
    end else begin
      case (mode_i)
        MODE_INC:   next_o = word_i + ONE;
        MODE_CONST: next_o = word_i;
        MODE_LFSR:  next_o = (word_i >> 1) ^ (word_i[0] ? TAP_MASK : ZERO);
        MODE_WALK:  next_o = {word_i[AXIS_WIDTH-2:0], word_i[AXIS_WIDTH-1]};
        default:    next_o = word_i;
      endcase
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream packet generator: framed packets with tlast, four data
// patterns, programmable length and inter-packet gap. All outputs registered.
module axis_pattern_gen
  import axis_pattern_pkg::*;
#(
  parameter int                    AXIS_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 16,
  parameter int                    GAP_WIDTH  = 8,
  parameter logic [AXIS_WIDTH-1:0] TAP_MASK   = AXIS_WIDTH'(DEFAULT_TAP_MASK)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [AXIS_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic                  m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  state_e state_q, state_d;
  logic   load;

  // Shadow configuration, captured at the start of every packet.
  logic [1:0]           mode_q,    mode_d;
  logic [LEN_WIDTH-1:0] len_q,     len_d;
  logic [GAP_WIDTH-1:0] gap_q,     gap_d;

  // Beat counter (1..len_q) and gap counter (1..gap_q).
  logic [LEN_WIDTH-1:0] beat_q,    beat_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;

  // Output registers.
  logic                  tvalid_q,  tvalid_d;
  logic [AXIS_WIDTH-1:0] tdata_q,   tdata_d;
  logic                  tlast_q,   tlast_d;
  logic                  busy_q,    busy_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;

  logic                  hs;
  logic                  last_hs;
  logic                  gap_done;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic [AXIS_WIDTH-1:0] dp_word;
  logic [1:0]            dp_mode;
  logic [AXIS_WIDTH-1:0] dp_next;

  assign hs       = tvalid_q & m_axis_tready;
  assign last_hs  = hs & tlast_q;
  assign gap_done = (gap_cnt_q == gap_q);
  assign len_eff  = (pkt_len == '0) ? LEN_ONE : pkt_len;

  // On a capture the live inputs feed the pattern unit to form the start
  // word; otherwise the current beat and the captured mode produce the next.
  assign dp_word = load ? seed : tdata_q;
  assign dp_mode = load ? mode : mode_q;

  axis_pattern_data #(
    .AXIS_WIDTH (AXIS_WIDTH),
    .TAP_MASK   (TAP_MASK)
  ) u_data (
    .word_i  (dp_word),
    .mode_i  (dp_mode),
    .start_i (load),
    .next_o  (dp_next)
  );

  // State register and all datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before the edge, so ordering inside this block does not matter.
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= MODE_INC;
      len_q     <= LEN_ONE;
      gap_q     <= '0;
      beat_q    <= '0;
      gap_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      beat_q    <= beat_d;
      gap_cnt_q <= gap_cnt_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Next-state logic; load marks every edge that starts a new packet.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        // A packet always runs to its tlast handshake; en only decides
        // whether another one follows.
        if (last_hs) begin
          if (gap_q != '0) begin
            state_d = GAP;
          end else if (en) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (!en) begin
          state_d = IDLE;
        end else if (gap_done) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the config, counter and output registers.
  always_comb begin
    mode_d    = mode_q;
    len_d     = len_q;
    gap_d     = gap_q;
    beat_d    = beat_q;
    gap_cnt_d = gap_cnt_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    pkt_cnt_d = last_hs ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    busy_d    = (state_d != IDLE);

    if (load) begin
      mode_d    = mode;
      len_d     = len_eff;
      gap_d     = gap;
      beat_d    = LEN_ONE;
      gap_cnt_d = '0;
      tvalid_d  = 1'b1;
      tdata_d   = dp_next;
      tlast_d   = (len_eff == LEN_ONE);
    end else if (last_hs) begin
      // Entering GAP (counting its first idle cycle) or IDLE.
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
      gap_cnt_d = GAP_ONE;
    end else if (hs) begin
      tdata_d = dp_next;
      beat_d  = beat_q + LEN_ONE;
      tlast_d = ((beat_q + LEN_ONE) == len_q);
    end else if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q + GAP_ONE;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed self-checking bench for axis_pattern_gen (default parameters).
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [15:0] pkt_len;
  logic [7:0]  gap;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic [15:0] pkt_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  axis_pattern_gen dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .mode          (mode),
    .seed          (seed),
    .pkt_len       (pkt_len),
    .gap           (gap),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic last);
    check({tag, ".tvalid"}, {31'd0, m_axis_tvalid}, 32'd1);
    check({tag, ".tdata"}, m_axis_tdata, data);
    check({tag, ".tlast"}, {31'd0, m_axis_tlast}, {31'd0, last});
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, ".tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    check({tag, ".tlast"}, {31'd0, m_axis_tlast}, 32'd0);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".pkt_count"}, {16'd0, pkt_count}, exp_cnt);
  endtask

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1; en = 1'b0; mode = 2'd0; seed = 32'h0; pkt_len = 16'd4; gap = 8'd2;
    m_axis_tready = 1'b1;
    tick();
    tick();
    check("rst.tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst.tdata", m_axis_tdata, 32'd0);
    check("rst.tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check_cnt("rst");
    reset = 1'b0;
    tick();
    check("idle.busy", {31'd0, busy}, 32'd0);
    check_idle_out("idle");

    // ---------------- increment packets with gap=2 ----------------
    mode = 2'd0; seed = 32'h10; pkt_len = 16'd4; gap = 8'd2; en = 1'b1;
    tick();
    check("inc.busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_beat("inc.p1", 32'h10 + i, i == 3);
      check_cnt("inc.p1");
      tick();
    end
    exp_cnt = 1;
    check_cnt("inc.last1");
    check_idle_out("inc.gap1");
    check("inc.gap_busy", {31'd0, busy}, 32'd1);
    tick();
    check_idle_out("inc.gap2");
    tick();
    for (int i = 0; i < 4; i++) begin
      check_beat("inc.p2", 32'h10 + i, i == 3);
      tick();
    end
    exp_cnt = 2;
    check_cnt("inc.last2");
    check_idle_out("inc.gap3");
    en = 1'b0;
    tick();
    check("inc.gap_stop_busy", {31'd0, busy}, 32'd0);
    check_idle_out("inc.gap_stop");

    // ---------------- LFSR with backpressure ----------------
    mode = 2'd2; seed = 32'h1; pkt_len = 16'd3; gap = 8'd1; en = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    check_beat("bp.b0", 32'h0000_0001, 1'b0);
    en = 1'b0;
    tick();
    check_beat("bp.b1", 32'h8020_0003, 1'b0);
    m_axis_tready = 1'b0;
    tick();
    check_beat("bp.b1_hold1", 32'h8020_0003, 1'b0);
    tick();
    check_beat("bp.b1_hold2", 32'h8020_0003, 1'b0);
    m_axis_tready = 1'b1;
    tick();
    check_beat("bp.b2", 32'hC030_0002, 1'b1);
    m_axis_tready = 1'b0;
    tick();
    check_beat("bp.b2_hold", 32'hC030_0002, 1'b1);
    check_cnt("bp.b2_hold");
    m_axis_tready = 1'b1;
    tick();
    exp_cnt = 3;
    check_cnt("bp.last");
    check_idle_out("bp.gap");
    tick();
    check("bp.idle_busy", {31'd0, busy}, 32'd0);

    // ---------------- back-to-back single-beat walking-one ----------------
    mode = 2'd3; seed = 32'h0; pkt_len = 16'd1; gap = 8'd0; en = 1'b1;
    tick();
    check_beat("b2b.first", 32'h1, 1'b1);
    check_cnt("b2b.first");
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_cnt++;
      check_beat("b2b.beat", 32'h1, 1'b1);
      check_cnt("b2b.beat");
    end
    en = 1'b0;
    tick();
    exp_cnt++;
    check_cnt("b2b.stop");
    check_idle_out("b2b.stop");
    check("b2b.stop_busy", {31'd0, busy}, 32'd0);

    // ---------------- graceful stop mid-packet ----------------
    mode = 2'd0; seed = 32'h0; pkt_len = 16'd5; gap = 8'd0; en = 1'b1;
    tick();
    check_beat("gs.b0", 32'd0, 1'b0);
    tick();
    check_beat("gs.b1", 32'd1, 1'b0);
    tick();
    check_beat("gs.b2", 32'd2, 1'b0);
    en = 1'b0;
    tick();
    check_beat("gs.b3", 32'd3, 1'b0);
    tick();
    check_beat("gs.b4", 32'd4, 1'b1);
    tick();
    exp_cnt++;
    check_cnt("gs.done");
    check_idle_out("gs.done");
    check("gs.busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    check_idle_out("gs.quiet");

    // ---------------- mid-packet reset ----------------
    mode = 2'd0; seed = 32'h100; pkt_len = 16'd8; gap = 8'd0; en = 1'b1;
    tick();
    check_beat("mr.b0", 32'h100, 1'b0);
    tick();
    tick();
    check_beat("mr.b2", 32'h102, 1'b0);
    reset = 1'b1;
    tick();
    exp_cnt = 0;
    check("mr.tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("mr.tdata", m_axis_tdata, 32'd0);
    check("mr.tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("mr.busy", {31'd0, busy}, 32'd0);
    check_cnt("mr");
    reset = 1'b0;
    tick();
    check_beat("mr.restart", 32'h100, 1'b0);

    // Inputs changed mid-packet must wait for the next capture.
    seed = 32'hFFFF_FFFF; pkt_len = 16'd0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check_beat("mr.beat", 32'h100 + i, i == 7);
    end

    // ---------------- edge values ----------------
    tick();
    exp_cnt++;
    check_beat("edge.len0", 32'hFFFF_FFFF, 1'b1);
    check_cnt("edge.len0");
    pkt_len = 16'd2;
    tick();
    exp_cnt++;
    check_beat("edge.wrap0", 32'hFFFF_FFFF, 1'b0);
    check_cnt("edge.wrap0");
    en = 1'b0;
    tick();
    check_beat("edge.wrap1", 32'h0000_0000, 1'b1);
    tick();
    exp_cnt++;
    check_cnt("edge.end");
    check_idle_out("edge.end");
    check("edge.busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
